alu181_acc_ctrl: RTL and testbench

- Accumulator/command sequencer sitting directly upstream of the 8-bit ALU181; drives its A, B, M, Cn and Sel inputs and captures its combinational F output.
- Accepts one command at a time over a valid/ready handshake, optionally writes the ALU result back into an internal accumulator, and returns the result plus flags over a valid/ready response channel.

---
 rtl/alu181_acc_ctrl.sv | 175 +++++++++++++++++
 tb/tb_alu181_acc_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu181_acc_ctrl.sv
// Purpose: accumulator/command sequencer that drives an external ALU181 and returns its result.
// Latency: accept edge to res_valid is 2 cycles (EXEC/EXEC_NOWB) or 1 cycle (LOAD/READ).
// Backpressure: one command in flight; cmd_ready stays low until the response is taken by res_ready.
module alu181_acc_ctrl #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_kind,
    input  logic [3:0]       cmd_sel,
    input  logic             cmd_m,
    input  logic             cmd_cn,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic             alu_M,
    output logic             alu_Cn,
    output logic [3:0]       alu_Sel,
    input  logic [WIDTH-1:0] alu_F,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             res_neg,
    output logic [WIDTH-1:0] acc_out,
    output logic [15:0]      done_cnt
);

    localparam logic [1:0] KIND_EXEC      = 2'b00;
    localparam logic [1:0] KIND_EXEC_NOWB = 2'b01;
    localparam logic [1:0] KIND_LOAD      = 2'b10;
    localparam logic [1:0] KIND_READ      = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        RESP  = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       kind_q;
    logic [WIDTH-1:0] acc;
    logic             fire_cmd;
    logic             fire_res;
    logic             is_exec_cmd;
    logic             res_load;
    logic [WIDTH-1:0] res_nxt;
    logic             acc_load;
    logic [WIDTH-1:0] acc_nxt;

    // cmd_ready is registered and only high in IDLE, so it alone qualifies the transfer
    assign fire_cmd    = (state == IDLE) && cmd_valid && cmd_ready;
    assign fire_res    = (state == RESP) && res_ready;
    assign is_exec_cmd = (cmd_kind == KIND_EXEC) || (cmd_kind == KIND_EXEC_NOWB);
    assign acc_out     = acc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and result/accumulator update selection
    always_comb begin
        state_nxt = state;
        res_load  = 1'b0;
        res_nxt   = res_data;
        acc_load  = 1'b0;
        acc_nxt   = acc;
        case (state)
            IDLE: begin
                if (fire_cmd) begin
                    case (cmd_kind)
                        KIND_LOAD: begin
                            acc_load  = 1'b1;
                            acc_nxt   = cmd_data;
                            res_load  = 1'b1;
                            res_nxt   = cmd_data;
                            state_nxt = RESP;
                        end
                        KIND_READ: begin
                            res_load  = 1'b1;
                            res_nxt   = acc;
                            state_nxt = RESP;
                        end
                        default: state_nxt = DRIVE;
                    endcase
                end
            end
            DRIVE: begin
                // ALU has settled on the registered operands by the closing edge
                res_load  = 1'b1;
                res_nxt   = alu_F;
                acc_load  = (kind_q == KIND_EXEC);
                acc_nxt   = alu_F;
                state_nxt = RESP;
            end
            RESP: begin
                if (fire_res) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            cmd_ready <= (state_nxt == IDLE);
            res_valid <= (state_nxt == RESP);
        end
    end

    // ALU operands only move on an EXEC accept so the ALU never sees idle toggling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_A   <= '0;
            alu_B   <= '0;
            alu_M   <= 1'b0;
            alu_Cn  <= 1'b0;
            alu_Sel <= 4'h0;
            kind_q  <= KIND_EXEC;
        end else if (fire_cmd && is_exec_cmd) begin
            alu_A   <= acc;
            alu_B   <= cmd_data;
            alu_M   <= cmd_m;
            alu_Cn  <= cmd_cn;
            alu_Sel <= cmd_sel;
            kind_q  <= cmd_kind;
        end
    end

    // Result register with its flags, loaded together so they never disagree
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data <= '0;
            res_zero <= 1'b0;
            res_neg  <= 1'b0;
        end else if (res_load) begin
            res_data <= res_nxt;
            res_zero <= (res_nxt == '0);
            res_neg  <= res_nxt[WIDTH-1];
        end
    end

    // Accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= ACC_RESET;
        end else if (acc_load) begin
            acc <= acc_nxt;
        end
    end

    // Completed-response counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= 16'h0000;
        end else if (fire_res) begin
            done_cnt <= done_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu181_acc_ctrl.sv
// Bench for alu181_acc_ctrl wired to a behavioural ALU181 model.
// Directed plan sequences, a constant vector table, then random commands vs a transaction model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu181_acc_ctrl;

    localparam logic [1:0] K_EXEC = 2'b00;
    localparam logic [1:0] K_NOWB = 2'b01;
    localparam logic [1:0] K_LOAD = 2'b10;
    localparam logic [1:0] K_READ = 2'b11;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_kind;
    logic [3:0] cmd_sel;
    logic       cmd_m;
    logic       cmd_cn;
    logic [7:0] cmd_data;
    logic [7:0] alu_A;
    logic [7:0] alu_B;
    logic       alu_M;
    logic       alu_Cn;
    logic [3:0] alu_Sel;
    logic [7:0] alu_F;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_zero;
    logic       res_neg;
    logic [7:0] acc_out;
    logic [15:0] done_cnt;

    int checks = 0;
    int errors = 0;

    // Active-high ALU181 function table; carry-in is added as an active-high +1 in this model
    function automatic logic [7:0] alu181(input logic [7:0] a, input logic [7:0] b,
                                          input logic m, input logic cn, input logic [3:0] s);
        logic [7:0] f;
        logic [7:0] c;
        c = {7'd0, cn};
        if (m) begin
            case (s)
                4'h0: f = ~a;
                4'h1: f = ~(a | b);
                4'h2: f = ~a & b;
                4'h3: f = 8'h00;
                4'h4: f = ~(a & b);
                4'h5: f = ~b;
                4'h6: f = a ^ b;
                4'h7: f = a & ~b;
                4'h8: f = ~a | b;
                4'h9: f = ~(a ^ b);
                4'hA: f = b;
                4'hB: f = a & b;
                4'hC: f = 8'hFF;
                4'hD: f = a | ~b;
                4'hE: f = a | b;
                default: f = a;
            endcase
        end else begin
            case (s)
                4'h0: f = a + c;
                4'h1: f = (a | b) + c;
                4'h2: f = (a | ~b) + c;
                4'h3: f = 8'hFF + c;
                4'h4: f = a + (a & ~b) + c;
                4'h5: f = (a | b) + (a & ~b) + c;
                4'h6: f = a - b - 8'd1 + c;
                4'h7: f = (a & ~b) - 8'd1 + c;
                4'h8: f = a + (a & b) + c;
                4'h9: f = a + b + c;
                4'hA: f = (a | ~b) + (a & b) + c;
                4'hB: f = (a & b) - 8'd1 + c;
                4'hC: f = a + a + c;
                4'hD: f = (a | b) + a + c;
                4'hE: f = (a | ~b) + a + c;
                default: f = a - 8'd1 + c;
            endcase
        end
        return f;
    endfunction

    assign alu_F = alu181(alu_A, alu_B, alu_M, alu_Cn, alu_Sel);

    alu181_acc_ctrl #(.WIDTH(8), .ACC_RESET(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
        .cmd_sel(cmd_sel), .cmd_m(cmd_m), .cmd_cn(cmd_cn), .cmd_data(cmd_data),
        .alu_A(alu_A), .alu_B(alu_B), .alu_M(alu_M), .alu_Cn(alu_Cn), .alu_Sel(alu_Sel),
        .alu_F(alu_F),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_zero(res_zero), .res_neg(res_neg), .acc_out(acc_out), .done_cnt(done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one command from a falling edge, take the response after 'hold' stalled cycles.
    task automatic run_cmd(input logic [1:0] kind, input logic [3:0] sel, input logic m,
                           input logic cn, input logic [7:0] data, input int hold,
                           output logic [7:0] r_data, output logic r_zero, output logic r_neg,
                           output int lat, output logic [7:0] d_a, output logic [7:0] d_b,
                           output logic d_m, output logic d_cn, output logic [3:0] d_sel);
        int budget;
        r_data = 8'hxx; r_zero = 1'bx; r_neg = 1'bx; lat = -1;
        d_a = 8'hxx; d_b = 8'hxx; d_m = 1'bx; d_cn = 1'bx; d_sel = 4'hx;
        cmd_valid = 1'b1; cmd_kind = kind; cmd_sel = sel; cmd_m = m; cmd_cn = cn; cmd_data = data;
        budget = 0;
        while (cmd_ready !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 20) begin
            check("accept_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = $urandom;
        lat = 1;
        d_a = alu_A; d_b = alu_B; d_m = alu_M; d_cn = alu_Cn; d_sel = alu_Sel;
        while (res_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 20) begin
            check("response_timeout", 32'd0, 32'd1);
            return;
        end
        r_data = res_data; r_zero = res_zero; r_neg = res_neg;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", res_valid, 1);
            check("hold_data", res_data, r_data);
            check("hold_cmd_ready", cmd_ready, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("res_valid_drop", res_valid, 0);
        check("cmd_ready_back", cmd_ready, 1);
    endtask

    typedef struct {
        logic [1:0] kind;
        logic [3:0] sel;
        logic       m;
        logic       cn;
        logic [7:0] data;
        logic [7:0] exp_res;
        logic [7:0] exp_acc;
    } vec_t;

    vec_t tbl[9];

    logic [7:0] r_data, d_a, d_b;
    logic       r_zero, r_neg, d_m, d_cn;
    logic [3:0] d_sel;
    int         lat;
    int         exp_done;
    logic [7:0] m_acc;

    initial begin
        tbl[0] = '{K_LOAD, 4'h0, 1'b0, 1'b0, 8'h3C, 8'h3C, 8'h3C};
        tbl[1] = '{K_EXEC, 4'h6, 1'b1, 1'b0, 8'h0F, 8'h33, 8'h33};
        tbl[2] = '{K_NOWB, 4'h9, 1'b0, 1'b0, 8'h01, 8'h34, 8'h33};
        tbl[3] = '{K_EXEC, 4'h9, 1'b0, 1'b1, 8'h0F, 8'h43, 8'h43};
        tbl[4] = '{K_READ, 4'h0, 1'b0, 1'b0, 8'h99, 8'h43, 8'h43};
        tbl[5] = '{K_EXEC, 4'h3, 1'b1, 1'b0, 8'h55, 8'h00, 8'h00};
        tbl[6] = '{K_EXEC, 4'hC, 1'b1, 1'b0, 8'h00, 8'hFF, 8'hFF};
        tbl[7] = '{K_EXEC, 4'hF, 1'b0, 1'b0, 8'h12, 8'hFE, 8'hFE};
        tbl[8] = '{K_NOWB, 4'h0, 1'b0, 1'b1, 8'h34, 8'hFF, 8'hFE};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_kind = 2'b00; cmd_sel = 4'h0;
        cmd_m = 1'b0; cmd_cn = 1'b0; cmd_data = 8'h00; res_ready = 1'b0;
        exp_done = 0;

        // 1. reset
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_flags", {res_zero, res_neg}, 0);
        check("rst_acc", acc_out, 0);
        check("rst_done", done_cnt, 0);
        check("rst_alu", {alu_A, alu_B, alu_M, alu_Cn, alu_Sel}, 0);
        rst_n = 1'b1;
        #1;
        check("rel_cmd_ready_before_edge", cmd_ready, 0);
        @(negedge clk);
        check("rel_cmd_ready_after_edge", cmd_ready, 1);

        // 2. LOAD 85
        run_cmd(K_LOAD, 4'h0, 1'b0, 1'b0, 8'h85, 1, r_data, r_zero, r_neg, lat, d_a, d_b, d_m, d_cn, d_sel);
        exp_done++;
        check("load_lat", lat, 1);
        check("load_data", r_data, 8'h85);
        check("load_flags", {r_zero, r_neg}, 2'b01);
        check("load_acc", acc_out, 8'h85);
        check("load_done", done_cnt, exp_done);

        // 3. EXEC A AND B
        run_cmd(K_EXEC, 4'hB, 1'b1, 1'b0, 8'hAA, 0, r_data, r_zero, r_neg, lat, d_a, d_b, d_m, d_cn, d_sel);
        exp_done++;
        check("exec_drive", {d_a, d_b, d_m, d_sel}, {8'h85, 8'hAA, 1'b1, 4'hB});
        check("exec_lat", lat, 2);
        check("exec_data", r_data, 8'h80);
        check("exec_flags", {r_zero, r_neg}, 2'b01);
        check("exec_acc", acc_out, 8'h80);

        // 4. EXEC_NOWB NOT A
        run_cmd(K_NOWB, 4'h0, 1'b1, 1'b0, 8'h00, 0, r_data, r_zero, r_neg, lat, d_a, d_b, d_m, d_cn, d_sel);
        exp_done++;
        check("nowb_data", r_data, 8'h7F);
        check("nowb_flags", {r_zero, r_neg}, 2'b00);
        check("nowb_acc", acc_out, 8'h80);
        check("nowb_alu_hold", {alu_A, alu_Sel}, {8'h80, 4'h0});

        // 5. backpressure with a second READ waiting throughout
        cmd_valid = 1'b1; cmd_kind = K_READ; cmd_data = 8'h00;
        @(negedge clk);
        check("bp_accept_first", res_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", res_valid, 1);
            check("bp_hold_data", res_data, 8'h80);
            check("bp_cmd_ready", cmd_ready, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_done++;
        check("bp_released_valid", res_valid, 0);
        check("bp_released_ready", cmd_ready, 1);
        check("bp_done", done_cnt, exp_done);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp_second_valid", res_valid, 1);
        check("bp_second_data", res_data, 8'h80);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_done++;
        check("bp_second_done", done_cnt, exp_done);

        // vector table
        for (int i = 0; i < 9; i++) begin
            run_cmd(tbl[i].kind, tbl[i].sel, tbl[i].m, tbl[i].cn, tbl[i].data, i % 3,
                    r_data, r_zero, r_neg, lat, d_a, d_b, d_m, d_cn, d_sel);
            exp_done++;
            check("tbl_res", r_data, tbl[i].exp_res);
            check("tbl_zero", r_zero, tbl[i].exp_res == 8'h00);
            check("tbl_neg", r_neg, tbl[i].exp_res[7]);
            check("tbl_acc", acc_out, tbl[i].exp_acc);
            check("tbl_done", done_cnt, exp_done);
        end

        // random commands against a transaction-level model
        m_acc = acc_out === 8'hFE ? 8'hFE : 8'hFE;
        for (int n = 0; n < 200; n++) begin
            logic [1:0] k;
            logic [3:0] s;
            logic       mm, cc;
            logic [7:0] dd, exp_r, exp_a;
            int         exp_lat;
            k = 2'($urandom_range(0, 3)); s = 4'($urandom_range(0, 15));
            mm = 1'($urandom_range(0, 1)); cc = 1'($urandom_range(0, 1));
            dd = 8'($urandom_range(0, 255));
            exp_a = m_acc;
            case (k)
                K_LOAD:  begin exp_r = dd;    exp_a = dd;    exp_lat = 1; end
                K_READ:  begin exp_r = m_acc;                exp_lat = 1; end
                K_EXEC:  begin exp_r = alu181(m_acc, dd, mm, cc, s); exp_a = exp_r; exp_lat = 2; end
                default: begin exp_r = alu181(m_acc, dd, mm, cc, s); exp_lat = 2; end
            endcase
            run_cmd(k, s, mm, cc, dd, $urandom_range(0, 2),
                    r_data, r_zero, r_neg, lat, d_a, d_b, d_m, d_cn, d_sel);
            exp_done++;
            check("rnd_res", r_data, exp_r);
            check("rnd_flags", {r_zero, r_neg}, {exp_r == 8'h00, exp_r[7]});
            check("rnd_lat", lat, exp_lat);
            check("rnd_acc", acc_out, exp_a);
            check("rnd_done", done_cnt, exp_done);
            if (k[1] == 1'b0)
                check("rnd_drive", {d_a, d_b, d_m, d_cn, d_sel}, {m_acc, dd, mm, cc, s});
            m_acc = exp_a;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // 6. reset in the middle of an EXEC
        cmd_valid = 1'b1; cmd_kind = K_EXEC; cmd_sel = 4'h9; cmd_m = 1'b0; cmd_cn = 1'b0; cmd_data = 8'h05;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("abort_in_drive", res_valid, 0);
        rst_n = 1'b0;
        #1;
        check("abort_res_valid", res_valid, 0);
        check("abort_acc", acc_out, 0);
        check("abort_done", done_cnt, 0);
        check("abort_alu", {alu_A, alu_B, alu_M, alu_Cn, alu_Sel}, 0);
        check("abort_res", {res_data, res_zero, res_neg, cmd_ready}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_resp", res_valid, 0);
        end
        run_cmd(K_LOAD, 4'h0, 1'b0, 1'b0, 8'h12, 0, r_data, r_zero, r_neg, lat, d_a, d_b, d_m, d_cn, d_sel);
        check("post_abort_data", r_data, 8'h12);
        check("post_abort_acc", acc_out, 8'h12);
        check("post_abort_done", done_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
